spi_mult_ctrl: RTL and testbench

//  Transaction sequencer for the SPI multiplier peripheral. Takes conditioned CS/SCLK edge strobes,

---
 rtl/spi_mult_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spi_mult_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module : spi_mult_ctrl
// Brief  : Sequences one SPI multiply transaction: operand frame in, multiplier
//          start/wait with timeout, product parallel-load and gated shift-out.
// Rev    : 1.0
// ============================================================================
module spi_mult_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CNT_W        = 4,
    parameter int MULT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cs_n,
    input  logic       i_sclk_posedge,
    input  logic       i_sclk_negedge,
    input  logic       i_mult_done,
    output logic [1:0] o_sr_mode,
    output logic       o_mult_start,
    output logic       o_miso_en,
    output logic       o_busy,
    output logic       o_err,
    output logic       o_xfer_done
);

    localparam int TMR_W = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] c_LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [TMR_W-1:0] c_TMR_LAST  = TMR_W'(MULT_TIMEOUT - 1);
    localparam logic [1:0]       c_SR_HOLD   = 2'b00;
    localparam logic [1:0]       c_SR_SHIFT  = 2'b01;
    localparam logic [1:0]       c_SR_PLOAD  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX    = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_LOAD  = 3'd4,
        S_TX    = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;

    logic [1:0] r_sr_mode;
    logic       r_mult_start;
    logic       r_miso_en;
    logic       r_busy;
    logic       r_err;
    logic       r_xfer_done;

    logic [1:0] w_sr_mode;
    logic       w_mult_start;
    logic       w_miso_en;
    logic       w_busy;
    logic       w_err;
    logic       w_xfer_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_timer      <= '0;
            r_sr_mode    <= c_SR_HOLD;
            r_mult_start <= 1'b0;
            r_miso_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_xfer_done  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_timer      <= w_timer_nxt;
            r_sr_mode    <= w_sr_mode;
            r_mult_start <= w_mult_start;
            r_miso_en    <= w_miso_en;
            r_busy       <= w_busy;
            r_err        <= w_err;
            r_xfer_done  <= w_xfer_done;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_timer_nxt   = r_timer;
        w_err         = r_err;
        w_xfer_done   = 1'b0;
        w_sr_mode     = c_SR_HOLD;
        w_mult_start  = 1'b0;
        w_miso_en     = 1'b0;
        w_busy        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!i_cs_n) begin
                    w_next        = S_RX;
                    w_err         = 1'b0;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_RX: begin
                if (i_sclk_posedge) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_next        = S_START;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                w_next      = S_WAIT;
                w_timer_nxt = '0;
            end
            S_WAIT: begin
                // A done arriving on the final timer cycle still wins over the timeout.
                if (i_mult_done) begin
                    w_next = S_LOAD;
                end else if (r_timer == c_TMR_LAST) begin
                    w_next = S_DONE;
                    w_err  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_LOAD: begin
                w_next        = S_TX;
                w_bit_cnt_nxt = '0;
            end
            S_TX: begin
                if (i_sclk_negedge) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_next        = S_DONE;
                        w_xfer_done   = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Chip-select release aborts everything; err keeps its last value.
        if ((r_state != S_IDLE) && i_cs_n) begin
            w_next        = S_IDLE;
            w_bit_cnt_nxt = '0;
            w_timer_nxt   = '0;
            w_err         = r_err;
            w_xfer_done   = 1'b0;
        end

        // Outputs are decoded from the next state so the registered copy lines up with it.
        case (w_next)
            S_RX:    w_sr_mode = c_SR_SHIFT;
            S_START: w_mult_start = 1'b1;
            S_LOAD:  w_sr_mode = c_SR_PLOAD;
            S_TX: begin
                w_sr_mode = c_SR_SHIFT;
                w_miso_en = 1'b1;
            end
            default: w_sr_mode = c_SR_HOLD;
        endcase
        w_busy = (w_next != S_IDLE);
    end

    assign o_sr_mode    = r_sr_mode;
    assign o_mult_start = r_mult_start;
    assign o_miso_en    = r_miso_en;
    assign o_busy       = r_busy;
    assign o_err        = r_err;
    assign o_xfer_done  = r_xfer_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_mult_ctrl
// Brief  : Randomized transactions checked against a phase-level expectation model.
// Rev    : 1.0
// ============================================================================
module tb_spi_mult_ctrl;

    localparam int DATA_W       = 8;
    localparam int CNT_W        = 4;
    localparam int MULT_TIMEOUT = 16;

    localparam int P_IDLE = 0, P_RX = 1, P_START = 2, P_WAIT = 3, P_LOAD = 4, P_TX = 5, P_DONE = 6;
    localparam int K_NORMAL = 0, K_TIMEOUT = 1, K_ABORT = 2, K_COLLIDE = 3, K_RESET = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       sclk_posedge;
    logic       sclk_negedge;
    logic       mult_done;
    logic [1:0] sr_mode;
    logic       mult_start;
    logic       miso_en;
    logic       busy;
    logic       err;
    logic       xfer_done;

    int total = 0;
    int bad   = 0;
    int n_start = 0, n_pload = 0, n_xfer = 0, n_miso = 0, n_illegal = 0;
    int tx_cycles;
    bit exp_err = 1'b0;
    bit noise;

    spi_mult_ctrl #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .MULT_TIMEOUT(MULT_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cs_n        (cs_n),
        .i_sclk_posedge(sclk_posedge),
        .i_sclk_negedge(sclk_negedge),
        .i_mult_done   (mult_done),
        .o_sr_mode     (sr_mode),
        .o_mult_start  (mult_start),
        .o_miso_en     (miso_en),
        .o_busy        (busy),
        .o_err         (err),
        .o_xfer_done   (xfer_done)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle, compared per transaction against the model.
    always @(negedge clk) begin
        if (mult_start === 1'b1) n_start++;
        if (sr_mode === 2'b10) n_pload++;
        if (xfer_done === 1'b1) n_xfer++;
        if (miso_en === 1'b1) n_miso++;
        if ((sr_mode === 2'b11) || (miso_en === 1'b1 && sr_mode !== 2'b01) ||
            (mult_start === 1'b1 && sr_mode !== 2'b00))
            n_illegal++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
        mult_done    = 1'b0;
    endtask

    function automatic logic [7:0] pack(input logic b, input logic [1:0] sr, input logic s,
                                        input logic m, input logic e, input logic x);
        return {b, sr, s, m, e, x, 1'b0};
    endfunction

    function automatic logic [7:0] outs();
        return pack(busy, sr_mode, mult_start, miso_en, err, xfer_done);
    endfunction

    function automatic logic [7:0] expv(input int ph, input bit x);
        case (ph)
            P_RX:    return pack(1'b1, 2'b01, 1'b0, 1'b0, exp_err, 1'b0);
            P_START: return pack(1'b1, 2'b00, 1'b1, 1'b0, exp_err, 1'b0);
            P_WAIT:  return pack(1'b1, 2'b00, 1'b0, 1'b0, exp_err, 1'b0);
            P_LOAD:  return pack(1'b1, 2'b10, 1'b0, 1'b0, exp_err, 1'b0);
            P_TX:    return pack(1'b1, 2'b01, 1'b0, 1'b1, exp_err, 1'b0);
            P_DONE:  return pack(1'b1, 2'b00, 1'b0, 1'b0, exp_err, x);
            default: return pack(1'b0, 2'b00, 1'b0, 1'b0, exp_err, 1'b0);
        endcase
    endfunction

    task automatic chk_ph(input string tag, input int ph, input bit x);
        logic [7:0] obs;
        logic [7:0] exp_v;
        obs   = outs();
        exp_v = expv(ph, x);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed{busy,sr,start,miso,err,xfer}=%b expected=%b",
                   tag, obs[7:1], exp_v[7:1]);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Idle cycles between strobes; with noise, wrong-direction edges and stray done are injected.
    task automatic gap(input bit in_tx);
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
            if (noise) begin
                if (in_tx) sclk_posedge = 1'b1;
                else       sclk_negedge = 1'b1;
                mult_done = 1'($urandom_range(0, 1));
            end
            tick();
            drop();
            if (in_tx) begin
                tx_cycles++;
                chk_ph("tx_gap", P_TX, 1'b0);
            end else begin
                chk_ph("rx_gap", P_RX, 1'b0);
            end
        end
    endtask

    task automatic rx_bits(input int n);
        for (int b = 0; b < n; b++) begin
            sclk_posedge = 1'b1;
            tick();
            drop();
            if (b < DATA_W - 1) begin
                chk_ph("rx_bit", P_RX, 1'b0);
                gap(1'b0);
            end else begin
                chk_ph("start_pulse", P_START, 1'b0);
            end
        end
    endtask

    task automatic tx_bits(input int n);
        for (int b = 0; b < n; b++) begin
            sclk_negedge = 1'b1;
            tick();
            drop();
            if (b < DATA_W - 1) begin
                tx_cycles++;
                chk_ph("tx_bit", P_TX, 1'b0);
                gap(1'b1);
            end else begin
                chk_ph("xfer_pulse", P_DONE, 1'b1);
            end
        end
    endtask

    task automatic run_xfer(input int kind, input int d_force);
        int s0, p0, x0, m0, i0;
        int exp_s, exp_p, exp_x, d, k;
        s0 = n_start; p0 = n_pload; x0 = n_xfer; m0 = n_miso; i0 = n_illegal;
        exp_s = 0; exp_p = 0; exp_x = 0;
        tx_cycles = 0;
        noise = 1'($urandom_range(0, 1));

        if (noise) begin
            mult_done = 1'b1; sclk_posedge = 1'b1; sclk_negedge = 1'b1;
            tick();
            drop();
            chk_ph("idle_noise", P_IDLE, 1'b0);
        end

        cs_n = 1'b0;
        tick();
        exp_err = 1'b0;
        chk_ph("rx_entry", P_RX, 1'b0);

        if (kind == K_ABORT) begin
            k = $urandom_range(0, DATA_W - 1);
            rx_bits(k);
            cs_n = 1'b1;
            tick();
            chk_ph("abort_idle", P_IDLE, 1'b0);
        end else if (kind == K_COLLIDE) begin
            rx_bits(DATA_W - 1);
            sclk_posedge = 1'b1;
            cs_n = 1'b1;
            tick();
            drop();
            chk_ph("collide_idle", P_IDLE, 1'b0);
        end else begin
            rx_bits(DATA_W);
            exp_s = 1;
            if (kind == K_TIMEOUT) begin
                for (int t = 0; t < MULT_TIMEOUT; t++) begin
                    tick();
                    chk_ph("wait_hold", P_WAIT, 1'b0);
                end
                tick();
                exp_err = 1'b1;
                chk_ph("timeout_done", P_DONE, 1'b0);
                mult_done = 1'b1;
                tick();
                drop();
                chk_ph("done_ignores_mult", P_DONE, 1'b0);
                if ($urandom_range(0, 1) == 0) begin
                    reset = 1'b1; cs_n = 1'b1;
                    tick();
                    reset = 1'b0;
                    exp_err = 1'b0;
                    chk_ph("reset_clears_err", P_IDLE, 1'b0);
                end else begin
                    cs_n = 1'b1;
                    tick();
                    chk_ph("abort_holds_err", P_IDLE, 1'b0);
                end
            end else begin
                d = (d_force > 0) ? d_force : int'($urandom_range(1, MULT_TIMEOUT));
                for (int t = 0; t < d; t++) begin
                    tick();
                    chk_ph("wait_hold", P_WAIT, 1'b0);
                end
                mult_done = 1'b1;
                tick();
                drop();
                exp_p = 1;
                chk_ph("pload", P_LOAD, 1'b0);
                tick();
                tx_cycles++;
                chk_ph("tx_entry", P_TX, 1'b0);
                if (kind == K_RESET) begin
                    tx_bits(3);
                    reset = 1'b1; cs_n = 1'b1;
                    tick();
                    reset = 1'b0;
                    chk_ph("reset_tx", P_IDLE, 1'b0);
                end else begin
                    tx_bits(DATA_W);
                    exp_x = 1;
                    tick();
                    chk_ph("xfer_single", P_DONE, 1'b0);
                    if (noise) begin
                        sclk_posedge = 1'b1; sclk_negedge = 1'b1; mult_done = 1'b1;
                        tick();
                        drop();
                        chk_ph("done_noise", P_DONE, 1'b0);
                    end
                    cs_n = 1'b1;
                    tick();
                    chk_ph("end_idle", P_IDLE, 1'b0);
                end
            end
        end

        chk_int("start_count", n_start - s0, exp_s);
        chk_int("pload_count", n_pload - p0, exp_p);
        chk_int("xfer_count", n_xfer - x0, exp_x);
        chk_int("miso_cycles", n_miso - m0, tx_cycles);
        chk_int("illegal_combo", n_illegal - i0, 0);
    endtask

    initial begin
        reset = 1'b1;
        cs_n  = 1'b1;
        drop();
        repeat (3) tick();
        chk_ph("reset_state", P_IDLE, 1'b0);
        reset = 1'b0;
        tick();
        chk_ph("idle_after_reset", P_IDLE, 1'b0);

        run_xfer(K_NORMAL, 3);
        run_xfer(K_TIMEOUT, 0);
        run_xfer(K_ABORT, 0);
        run_xfer(K_COLLIDE, 0);
        run_xfer(K_NORMAL, MULT_TIMEOUT);
        run_xfer(K_RESET, 0);
        for (int i = 0; i < 30; i++) begin
            run_xfer(int'($urandom_range(0, 4)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
